// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops burst_len words from a 1-cycle-latency FIFO and
// forwards them through a small in-order skid buffer to a valid/ready sink,
// reporting a per-burst word count, XOR checksum and a done pulse.
module fifo_burst_reader #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  input  logic              empty,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  words_read,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SLT_W = OCC_W + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic                inflight_q, inflight_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [DATA_W-1:0]   mem_q [BUF_DEPTH];
  logic [DATA_W-1:0]   mem_d [BUF_DEPTH];
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    words_read_q, words_read_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;

  logic                pop_c;
  logic                read_en_c;
  logic [SLT_W-1:0]    slots_used_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid  = (occ_q != '0);
  assign out_data   = mem_q[head_q];
  assign read_en    = read_en_c;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_read = words_read_q;
  assign checksum   = checksum_q;

  // Pop request: a slot freed by this cycle's downstream pop counts as free,
  // which keeps one word per cycle with only two entries.
  always_comb begin
    pop_c        = out_valid && out_ready;
    slots_used_c = SLT_W'(occ_q) + SLT_W'(inflight_q) - SLT_W'(pop_c);
    read_en_c    = (state_q == BURST) && !empty && (issued_q < len_q) &&
                   (slots_used_c < SLT_W'(BUF_DEPTH));
  end

  // Next-state: burst control, skid buffer push/pop, counters.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    issued_d     = issued_q;
    inflight_d   = read_en_c;
    occ_d        = occ_q;
    head_d       = head_q;
    tail_d       = tail_q;
    mem_d        = mem_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    words_read_d = words_read_q;
    checksum_d   = checksum_q;

    if (inflight_q) begin
      mem_d[tail_q] = read_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop_c) begin
      head_d = ptr_inc(head_q);
    end
    occ_d = occ_q + OCC_W'(inflight_q) - OCC_W'(pop_c);

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d        = burst_len;
          issued_d     = '0;
          words_read_d = '0;
          checksum_d   = '0;
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
            busy_d  = 1'b1;
          end
        end
      end
      BURST: begin
        if (read_en_c) begin
          issued_d = issued_q + CNT_W'(1);
        end
        if (pop_c) begin
          words_read_d = words_read_q + CNT_W'(1);
          checksum_d   = checksum_q ^ out_data;
          if ((words_read_q + CNT_W'(1)) == len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that drops buffered/in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      mem_q        <= '{default: '0};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_read_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      mem_q        <= mem_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      words_read_q <= words_read_d;
      checksum_q   <= checksum_d;
    end
  end

endmodule
